// File: rtl/sn_pkg.sv
// rtl/sn_pkg.sv - shared types and helpers for the thermometer expander
package sn_pkg;

   typedef enum logic {IDLE, SEND} sn_state_t;

   function automatic int cw_of(input int n);
      return $clog2(n + 1);
   endfunction

   function automatic int beats_of(input int n, input int lane);
      return n / lane;
   endfunction

   function automatic int bw_of(input int beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

   // Thermometer bit k of a count is set when the count reaches past k.
   function automatic logic therm_bit(input int unsigned count, input int unsigned k);
      return count > k;
   endfunction

endpackage

// File: rtl/sn_therm_slice.sv
// rtl/sn_therm_slice.sv - combinational LANE-bit slice of the thermometer code
module sn_therm_slice
   import sn_pkg::*;
#(
   parameter int LANE = 4,
   parameter int CW   = 4,
   parameter int BW   = 1
) (
   input  logic [CW-1:0]   count,
   input  logic [BW-1:0]   beat,
   output logic [LANE-1:0] slice
);

   always_comb begin
      slice = '0;
      for (int i = 0; i < LANE; i++) begin
         slice[i] = therm_bit(32'(count), 32'(beat) * 32'(LANE) + 32'(i));
      end
   end

endmodule

// File: rtl/sn_therm_expander.sv
// rtl/sn_therm_expander.sv - binary count to streamed thermometer code expander
module sn_therm_expander
   import sn_pkg::*;
#(
   parameter  int N     = 8,
   parameter  int LANE  = 4,
   localparam int CW    = cw_of(N),
   localparam int BEATS = beats_of(N, LANE),
   localparam int BW    = bw_of(BEATS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [CW-1:0]   in_count,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [LANE-1:0] out_therm,
   output logic [BW-1:0]   out_beat,
   output logic            out_last,
   output logic            err_ovf
);

   if (N < 2 || LANE < 1 || (N % LANE) != 0) begin : g_bad_params
      $error("sn_therm_expander: N must be >= 2 and a multiple of LANE");
   end

   sn_state_t       state, state_nxt;
   logic [CW-1:0]   count, count_nxt;
   logic [BW-1:0]   beat, beat_nxt;
   logic [LANE-1:0] slice;
   logic            is_last;
   logic            accept;
   logic            ovf;
   logic [CW-1:0]   sat_count;

   assign is_last   = (state == SEND) && (beat == BW'(BEATS - 1));
   assign in_ready  = (state == IDLE) || (is_last && out_ready);
   assign accept    = in_valid && in_ready;
   assign ovf       = in_count > CW'(N);
   assign sat_count = ovf ? CW'(N) : in_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         count   <= '0;
         beat    <= '0;
         err_ovf <= 1'b0;
      end else begin
         state   <= state_nxt;
         count   <= count_nxt;
         beat    <= beat_nxt;
         err_ovf <= accept && ovf;
      end
   end

   always_comb begin
      state_nxt = state;
      count_nxt = count;
      beat_nxt  = beat;
      case (state)
         IDLE: begin
            if (accept) begin
               count_nxt = sat_count;
               beat_nxt  = '0;
               state_nxt = SEND;
            end
         end
         SEND: begin
            if (out_ready) begin
               if (!is_last) begin
                  beat_nxt = beat + BW'(1);
               end else if (accept) begin
                  // Back-to-back words: reload without an idle cycle.
                  count_nxt = sat_count;
                  beat_nxt  = '0;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   sn_therm_slice #(
      .LANE (LANE),
      .CW   (CW),
      .BW   (BW)
   ) u_slice (
      .count (count),
      .beat  (beat),
      .slice (slice)
   );

   assign out_valid = (state == SEND);
   assign out_beat  = beat;
   assign out_last  = is_last;
   assign out_therm = out_valid ? slice : '0;

endmodule
